// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - timing types, mode presets and helpers for the VGA raster generator
package vga_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam vga_mode_t VGA_800x600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

    function automatic int unsigned total(input vga_timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the generator to the pixel pipeline
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          pix_ce;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          rd_visible;
    logic          line_start;
    logic          frame_start;
    logic          hsync;
    logic          vsync;
    logic          vga_visible;

    modport master (
        output pix_ce, hcount, vcount, rd_visible, line_start, frame_start,
               hsync, vsync, vga_visible
    );

    modport slave (
        input pix_ce, hcount, vcount, rd_visible, line_start, frame_start,
              hsync, vsync, vga_visible
    );
endinterface

// File: rtl/pix_ce_div.sv
// rtl/pix_ce_div.sv - one-clk-wide clock-enable every DIV clocks, first pulse DIV clocks after clr drops
module pix_ce_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic ce
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= (cnt == LAST);
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing on the system clock with a pixel clock-enable
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned PIX_FREQ   = 25_000_000,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    vga_timing_gen_if.master   vif
);
    localparam vga_timing_t H_TIM = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam vga_timing_t V_TIM = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned H_TOTAL = total(H_TIM);
    localparam int unsigned V_TOTAL = total(V_TIM);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int unsigned DIV = CLK_FREQ / PIX_FREQ;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (DIV < 1 || (CLK_FREQ % PIX_FREQ) != 0) begin : g_bad_div
        $fatal(1, "vga_timing_gen: CLK_FREQ/PIX_FREQ must be an integer >= 1");
    end
    if (PIPE_DELAY < 1) begin : g_bad_delay
        $fatal(1, "vga_timing_gen: PIPE_DELAY must be >= 1");
    end

    logic          running;
    logic          hold;
    logic          pix_ce;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          vis0;
    logic          hs0;
    logic          vs0;
    logic [PIPE_DELAY-1:0][2:0] dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= en;
    end

    // Clearing on en as well as running makes a drop of en take effect on the
    // same edge that running falls, so no output lingers for a cycle.
    assign hold = !(en && running);

    pix_ce_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hold),
        .ce    (pix_ce)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hold) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign vis0 = running && (hcount < H_VIS_END) && (vcount < V_VIS_END);
    assign hs0  = running && (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    assign vs0  = running && (vcount >= VS_FIRST) && (vcount <= VS_LAST);

    // Matches framebuffer read latency: stage PIPE_DELAY-1 carries the decode
    // of the pixel issued PIPE_DELAY ticks earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else if (hold) begin
            dly <= '0;
        end else if (pix_ce) begin
            for (int i = PIPE_DELAY - 1; i > 0; i--) dly[i] <= dly[i-1];
            dly[0] <= {hs0, vs0, vis0};
        end
    end

    assign vif.pix_ce      = pix_ce;
    assign vif.hcount      = hcount;
    assign vif.vcount      = vcount;
    assign vif.rd_visible  = vis0;
    assign vif.line_start  = pix_ce && (hcount == '0);
    assign vif.frame_start = pix_ce && (hcount == '0) && (vcount == '0);
    assign vif.hsync       = dly[PIPE_DELAY-1][2] ? HS_POL : ~HS_POL;
    assign vif.vsync       = dly[PIPE_DELAY-1][1] ? VS_POL : ~VS_POL;
    assign vif.vga_visible = dly[PIPE_DELAY-1][0];
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the successor to the fixed 640x480 timing used on the Nexys4 DDR top, and replaces the free-running clk/4 divider there. It runs entirely on the 100 MHz system clock with an internal pixel clock-enable instead of a derived clock. It outputs undelayed pixel coordinates for framebuffer address issue, plus sync and visible outputs delayed by a configurable number of pixels to match framebuffer read latency.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
PIX_FREQ, 25_000_000, pixel rate in Hz; DIV = CLK_FREQ/PIX_FREQ must be an integer >= 1 (elaboration-time check, fatal otherwise)
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch in lines
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
PIPE_DELAY, 2, pixel ticks between coordinate output and sync/visible output; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low = synchronous restart and idle
pix_ce  out  1  pixel clock-enable, one clk wide
hcount  out  $clog2(H_TOTAL)  current pixel column, undelayed
vcount  out  $clog2(V_TOTAL)  current line, undelayed
rd_visible  out  1  (hcount,vcount) lies in the active area, undelayed
line_start  out  1  one-clk pulse on the pix_ce of hcount==0
frame_start  out  1  one-clk pulse on the pix_ce of hcount==0, vcount==0
hsync  out  1  delayed horizontal sync
vsync  out  1  delayed vertical sync
vga_visible  out  1  delayed active-area flag, used to blank RGB

Behaviour:
- H_TOTAL = sum of H_* parameters (800). V_TOTAL = sum of V_* parameters (525).
- Reset values: pix_ce=0, hcount=0, vcount=0, rd_visible=0, line_start=0, frame_start=0, vga_visible=0, hsync=~HS_POL, vsync=~VS_POL. All delay stages are cleared to inactive.
- running register:
  - Reset to 0.
  - Takes the value of en each clk.
  - While running=0, the divider, counters and delay stages are synchronously held at their reset values.
  - While running=0, all outputs are at their reset values.
- Divider:
  - div_cnt counts 0..DIV-1 while running.
  - pix_ce = running && div_cnt==DIV-1, registered so it is glitch-free.
  - DIV==1 gives pix_ce permanently high while running.
  - First pix_ce occurs DIV clks after running rises.
- Counters:
  - Advance only at the end of a pix_ce cycle.
  - hcount==H_TOTAL-1 wraps to 0 and increments vcount.
  - vcount==V_TOTAL-1 wraps to 0 together with the hcount wrap.
  - (hcount,vcount) are stable across the DIV clks of a pixel.
- Stage-0 decode from the counters, gated by running:
  - vis0 = hcount<H_VISIBLE && vcount<V_VISIBLE.
  - hs0 is active for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
  - vs0 is active for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
  - rd_visible = vis0.
- Delay line:
  - PIPE_DELAY stages of {hs0, vs0, vis0}, shifted only on pix_ce.
  - hsync, vsync and vga_visible are driven from the last stage and mapped to the polarity parameters.
  - Output at tick N reflects the decode of tick N-PIPE_DELAY and holds between ticks.
- line_start = pix_ce && hcount==0. frame_start = line_start && vcount==0.
- Reset or en low mid-frame: everything returns to reset values. The restart always begins at (0,0) with a fresh frame_start; no partial sync pulse is extended.
- Parameter widths come from $clog2 of the totals. Comparisons are unsigned and sized to the counter width.

Decomposition:
- Package vga_pkg: typedef struct vga_timing_t {visible, front, sync, back}.
- vga_pkg: localparam presets VGA_640x480_60 and VGA_800x600_60.
- vga_pkg: function total(vga_timing_t).
- Sub-module pix_ce_div (parameter DIV; ports clk, rst_n, clr, ce): the divider, reusable for other clock-enable domains.

Test Plan:
- Default params, en=1 after reset → pix_ce every 4th clk; hcount 799→0 with vcount +1; exactly 1,680,000 clks between successive frame_start pulses.
- Default params → hsync low for exactly 96 pix_ce ticks, beginning 2 ticks after hcount==656. vsync low for exactly 2*800 ticks, beginning 2 ticks after vcount==490, hcount==0.
- DIV=1, H=4/1/2/1, V=3/1/1/1, PIPE_DELAY=1, exhaustive → pix_ce constant 1. Every (hcount,vcount) pair and every output bit match the reference model over 3 frames.
- vga_visible high exactly 640 ticks per active line and 307,200 ticks per frame. rd_visible leads vga_visible by exactly PIPE_DELAY ticks.
- Assert rst_n low at hcount=700, vcount=491 (hsync and vsync both active) → all outputs at reset values asynchronously. After release: frame_start on the first pix_ce, 4 clks after running rises.
- HS_POL=1, VS_POL=1, en dropped mid-line then raised → syncs idle low, active high. en low forces counters to 0 within 1 clk. Restart reproduces the frame-0 output sequence bit-exactly.
